// File: rtl/wbc_mem_param.sv
// wbc_mem_param: Wishbone classic slave with a single-port, byte-lane-writable
// RAM. The wait-state counts for reads and writes are set by parameters.
// Optional feature macro: WBC_MEM_ERR_EN. When it is defined, the wb_err_o
// port exists, and an out-of-range access answers with err instead of ack.
//
// Handshake: a request is cyc&stb seen in IDLE. Its fields are captured on
// that edge. The slave answers with exactly one single-cycle ack (or err)
// after 1+wait cycles. Dropping cyc or stb while waiting abandons the transfer
// silently. A master still holding cyc&stb in the cycle after ack is
// issuing a new request.
module wbc_mem_param #(
  parameter int    DW        = 16,
  parameter int    AW        = 13,
  parameter int    DEPTH     = 8192,
  parameter int    RD_WAIT   = 1,
  parameter int    WR_WAIT   = 0,
  parameter string INIT_FILE = "none"
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [15:0]     wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic            wb_ack_o
`ifdef WBC_MEM_ERR_EN
  ,
  output logic            wb_err_o
`endif
);

  localparam int BO = (DW == 32) ? 2 : 1;
  localparam int SW = DW / 8;
  localparam logic [1:0] RD_LAST = 2'(RD_WAIT - 1);
  localparam logic [1:0] WR_LAST = 2'(WR_WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state, next_state;
  logic [1:0]    cnt, next_cnt;
  logic          req_valid;
  logic          go_ack;
  logic          mem_we;
  logic          cur_in_range;
  logic [AW-1:0] live_idx, req_idx, cur_idx;
  logic [DW-1:0] req_dat, cur_dat;
  logic [SW-1:0] req_sel, cur_sel;
  logic          req_we, cur_we;

  logic [DW-1:0] mem [0:DEPTH-1];

  assign req_valid = wb_cyc_i & wb_stb_i;
  assign live_idx  = wb_adr_i[AW+BO-1:BO];

  // Byte-offset bits and any address bits above the word index are not decoded.
  logic unused_lo;
  assign unused_lo = ^wb_adr_i[BO-1:0];
  if (AW + BO < 16) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^wb_adr_i[15:AW+BO];
  end

  // If DEPTH fills the whole index space, no address can fall out of range.
  if (DEPTH >= (1 << AW)) begin : g_full
    assign cur_in_range = 1'b1;
  end else begin : g_partial
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    assign cur_in_range = (cur_idx < DEPTH_A);
  end

  // A zero-wait transfer leaves IDLE and enters ACK on the same edge.
  // That edge must therefore act on the live bus fields; later edges act on the captured copy.
  always_comb begin
    cur_idx = req_idx;
    cur_dat = req_dat;
    cur_sel = req_sel;
    cur_we  = req_we;
    if (state == IDLE) begin
      cur_idx = live_idx;
      cur_dat = wb_dat_i;
      cur_sel = wb_sel_i;
      cur_we  = wb_we_i;
    end
  end

  // Next-state logic. go_ack marks the edge that enters ACK.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    go_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if ((wb_we_i ? WR_WAIT : RD_WAIT) == 0) begin
            next_state = ACK;
            go_ack     = 1'b1;
          end else begin
            next_state = WAIT;
            next_cnt   = 2'd0;
          end
        end
      end
      WAIT: begin
        if (!req_valid) begin
          next_state = IDLE;
          next_cnt   = 2'd0;
        end else if (cnt == (req_we ? WR_LAST : RD_LAST)) begin
          next_state = ACK;
          next_cnt   = 2'd0;
          go_ack     = 1'b1;
        end else begin
          next_cnt = cnt + 2'd1;
        end
      end
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign mem_we = go_ack & cur_we & cur_in_range & ~wb_rst_i;

  // Control state, captured request, and registered response outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      req_idx  <= '0;
      req_dat  <= '0;
      req_sel  <= '0;
      req_we   <= 1'b0;
`ifdef WBC_MEM_ERR_EN
      wb_err_o <= 1'b0;
`endif
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (state == IDLE && req_valid) begin
        req_idx <= live_idx;
        req_dat <= wb_dat_i;
        req_sel <= wb_sel_i;
        req_we  <= wb_we_i;
      end
`ifdef WBC_MEM_ERR_EN
      wb_ack_o <= go_ack & cur_in_range;
      wb_err_o <= go_ack & ~cur_in_range;
      if (go_ack && !cur_we && cur_in_range) begin
        wb_dat_o <= mem[cur_idx];
      end
`else
      wb_ack_o <= go_ack;
      if (go_ack && !cur_we) begin
        if (cur_in_range) begin
          wb_dat_o <= mem[cur_idx];
        end else begin
          wb_dat_o <= '0;
        end
      end
`endif
    end
  end

  // RAM write port. Only the enabled byte lanes are updated; the contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (cur_sel[b]) begin
          mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
        end
      end
    end
  end

endmodule
